// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one-entry hold buffer and redirect handling
//
// Purpose:
//   Holds the program counter, issues fetch requests to instruction memory and
//   presents each returned word exactly once on a registered IF/ID interface.
//   A one-entry hold buffer absorbs a word that returns while decode is stalled,
//   so a stall never drops or repeats an instruction. Redirects (jr > jump >
//   branch) retarget the PC immediately and squash anything in flight.
//
// Ports:
//   clk, reset            - clock; asynchronous active-high reset
//   imem_req, imem_addr   - fetch request and address (address is the PC)
//   imem_ready, imem_rdata- memory returns a word this cycle
//   stall                 - decode cannot accept a new instruction
//   redirect_base         - PC+4 of the redirecting instruction
//   branch_taken, branch_offset - conditional branch redirect, signed word offset
//   jump, jump_index      - absolute jump redirect within the current 256 MB region
//   jr, jr_target         - register-indirect redirect
//   if_valid, if_instr, if_pc, if_pc4 - registered IF/ID outputs

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [31:0] redirect_base,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] opc4_q, opc4_d;
  logic [31:0] hbuf_instr_q, hbuf_instr_d;
  logic [31:0] hbuf_pc_q, hbuf_pc_d;
  logic [31:0] hbuf_pc4_q, hbuf_pc4_d;

  logic        out_open;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] redirect_tgt;

  // Target arithmetic is independent of state, so keep it outside the FSM.
  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    branch_tgt = redirect_base + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    jump_tgt   = {redirect_base[31:28], jump_index, 2'b00};
    jr_tgt     = jr_target & 32'hFFFF_FFFC;
    redirect   = jr | jump | branch_taken;
    if (jr) begin
      redirect_tgt = jr_tgt;
    end else if (jump) begin
      redirect_tgt = jump_tgt;
    end else begin
      redirect_tgt = branch_tgt;
    end
  end

  // The output register may take a new word when it is empty or being consumed.
  assign out_open = !valid_q || !stall;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    opc_d        = opc_q;
    opc4_d       = opc4_q;
    hbuf_instr_d = hbuf_instr_q;
    hbuf_pc_d    = hbuf_pc_q;
    hbuf_pc4_d   = hbuf_pc4_q;
    // Gated by reset so the request drops the moment reset asserts.
    imem_req     = (state_q == ST_FETCH) && !reset;

    if (redirect) begin
      // Redirect wins over stall and over any word returning this cycle;
      // the abandoned request is simply not reissued.
      pc_d         = redirect_tgt;
      valid_d      = 1'b0;
      state_d      = ST_FETCH;
      hbuf_instr_d = 32'h0;
      hbuf_pc_d    = 32'h0;
      hbuf_pc4_d   = 32'h0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ready) begin
            pc_d = pc_plus4;
            if (out_open) begin
              valid_d = 1'b1;
              instr_d = imem_rdata;
              opc_d   = pc_q;
              opc4_d  = pc_plus4;
            end else begin
              // Decode is full and stalled: park the word instead of losing it.
              hbuf_instr_d = imem_rdata;
              hbuf_pc_d    = pc_q;
              hbuf_pc4_d   = pc_plus4;
              state_d      = ST_HOLD;
            end
          end else if (out_open) begin
            valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          // Entering HOLD implies valid_q=1, so the only release is stall=0.
          if (!stall) begin
            valid_d      = 1'b1;
            instr_d      = hbuf_instr_q;
            opc_d        = hbuf_pc_q;
            opc4_d       = hbuf_pc4_q;
            hbuf_instr_d = 32'h0;
            hbuf_pc_d    = 32'h0;
            hbuf_pc4_d   = 32'h0;
            state_d      = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      instr_q      <= 32'h0;
      opc_q        <= 32'h0;
      opc4_q       <= 32'h0;
      hbuf_instr_q <= 32'h0;
      hbuf_pc_q    <= 32'h0;
      hbuf_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      opc_q        <= opc_d;
      opc4_q       <= opc4_d;
      hbuf_instr_q <= hbuf_instr_d;
      hbuf_pc_q    <= hbuf_pc_d;
      hbuf_pc4_q   <= hbuf_pc4_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = opc_q;
  assign if_pc4    = opc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit

module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [31:0] redirect_base;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;

  logic        imem_req,  w_imem_req;
  logic [31:0] imem_addr, w_imem_addr;
  logic        if_valid,  w_if_valid;
  logic [31:0] if_instr,  w_if_instr;
  logic [31:0] if_pc,     w_if_pc;
  logic [31:0] if_pc4,    w_if_pc4;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_base(redirect_base),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index),
    .jr(jr), .jr_target(jr_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_base(redirect_base),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index),
    .jr(jr), .jr_target(jr_target),
    .if_valid(w_if_valid), .if_instr(w_if_instr), .if_pc(w_if_pc), .if_pc4(w_if_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    imem_ready    = 1'b0;
    imem_rdata    = 32'h0;
    stall         = 1'b0;
    redirect_base = 32'h0;
    branch_taken  = 1'b0;
    branch_offset = 16'h0;
    jump          = 1'b0;
    jump_index    = 26'h0;
    jr            = 1'b0;
    jr_target     = 32'h0;
  endtask

  // Reference model: a PC, the presented instruction, and a queue standing in
  // for the single word that may be waiting behind a stalled decode stage.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } word_t;

  logic [31:0] m_pc;
  logic        m_valid;
  word_t       m_out;
  word_t       m_wait[$];

  task automatic model_reset(input logic [31:0] rpc);
    m_pc      = rpc;
    m_valid   = 1'b0;
    m_out.instr = 32'h0;
    m_out.pc    = 32'h0;
    m_wait.delete();
  endtask

  task automatic model_edge();
    int          off;
    logic [31:0] tgt;
    word_t       w;
    if (reset) begin
      model_reset(32'h0);
    end else if (jr || jump || branch_taken) begin
      off = $signed(branch_offset);
      if (jr)        tgt = jr_target - (jr_target % 4);
      else if (jump) tgt = (redirect_base & 32'hF000_0000) | (32'(jump_index) * 4);
      else           tgt = redirect_base + 32'(off * 4);
      m_pc    = tgt;
      m_valid = 1'b0;
      m_wait.delete();
    end else if (m_wait.size() != 0) begin
      if (!stall) begin
        m_out   = m_wait.pop_front();
        m_valid = 1'b1;
      end
    end else if (imem_ready) begin
      w.instr = imem_rdata;
      w.pc    = m_pc;
      if (!m_valid || !stall) begin
        m_out   = w;
        m_valid = 1'b1;
      end else begin
        m_wait.push_back(w);
      end
      m_pc = m_pc + 32'd4;
    end else if (!m_valid || !stall) begin
      m_valid = 1'b0;
    end
  endtask

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        stl;
    logic        br;
    logic [15:0] off;
    logic        jmp;
    logic [25:0] idx;
    logic        jrr;
    logic [31:0] jrt;
    logic [31:0] base;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vt[18];

  initial begin
    vt[0]  = '{1'b1, 32'h0,       1'b0, 1'b0, 16'h0,    1'b0, 26'h0,   1'b0, 32'h0,    32'h0,         1'b1, 32'h4,         1'b1, 32'h0,         32'h0};
    vt[1]  = '{1'b1, 32'h4,       1'b0, 1'b0, 16'h0,    1'b0, 26'h0,   1'b0, 32'h0,    32'h0,         1'b1, 32'h8,         1'b1, 32'h4,         32'h4};
    vt[2]  = '{1'b1, 32'h8,       1'b0, 1'b0, 16'h0,    1'b0, 26'h0,   1'b0, 32'h0,    32'h0,         1'b1, 32'hC,         1'b1, 32'h8,         32'h8};
    vt[3]  = '{1'b1, 32'hC,       1'b0, 1'b0, 16'h0,    1'b0, 26'h0,   1'b0, 32'h0,    32'h0,         1'b1, 32'h10,        1'b1, 32'hC,         32'hC};
    vt[4]  = '{1'b1, 32'h10,      1'b1, 1'b0, 16'h0,    1'b0, 26'h0,   1'b0, 32'h0,    32'h0,         1'b0, 32'h14,        1'b1, 32'hC,         32'hC};
    vt[5]  = '{1'b1, 32'hDEAD,    1'b1, 1'b0, 16'h0,    1'b0, 26'h0,   1'b0, 32'h0,    32'h0,         1'b0, 32'h14,        1'b1, 32'hC,         32'hC};
    vt[6]  = '{1'b0, 32'h0,       1'b0, 1'b0, 16'h0,    1'b0, 26'h0,   1'b0, 32'h0,    32'h0,         1'b1, 32'h14,        1'b1, 32'h10,        32'h10};
    vt[7]  = '{1'b1, 32'h14,      1'b0, 1'b0, 16'h0,    1'b0, 26'h0,   1'b0, 32'h0,    32'h0,         1'b1, 32'h18,        1'b1, 32'h14,        32'h14};
    vt[8]  = '{1'b0, 32'h0,       1'b0, 1'b0, 16'h0,    1'b0, 26'h0,   1'b0, 32'h0,    32'h0,         1'b1, 32'h18,        1'b0, 32'h0,         32'h0};
    vt[9]  = '{1'b1, 32'hBAD,     1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0,   1'b0, 32'h0,    32'h100,       1'b1, 32'hF8,        1'b0, 32'h0,         32'h0};
    vt[10] = '{1'b1, 32'hBAD,     1'b0, 1'b0, 16'h0,    1'b1, 26'h123, 1'b1, 32'h2003, 32'h100,       1'b1, 32'h2000,      1'b0, 32'h0,         32'h0};
    vt[11] = '{1'b1, 32'h2000,    1'b0, 1'b0, 16'h0,    1'b0, 26'h0,   1'b0, 32'h0,    32'h0,         1'b1, 32'h2004,      1'b1, 32'h2000,      32'h2000};
    vt[12] = '{1'b1, 32'hBAD,     1'b0, 1'b0, 16'h0,    1'b1, 26'h40,  1'b0, 32'h0,    32'hA000_0000, 1'b1, 32'hA000_0100, 1'b0, 32'h0,         32'h0};
    vt[13] = '{1'b0, 32'h0,       1'b1, 1'b0, 16'h0,    1'b0, 26'h0,   1'b0, 32'h0,    32'h0,         1'b1, 32'hA000_0100, 1'b0, 32'h0,         32'h0};
    vt[14] = '{1'b1, 32'h55,      1'b1, 1'b0, 16'h0,    1'b0, 26'h0,   1'b0, 32'h0,    32'h0,         1'b1, 32'hA000_0104, 1'b1, 32'hA000_0100, 32'h55};
    vt[15] = '{1'b1, 32'h66,      1'b1, 1'b0, 16'h0,    1'b0, 26'h0,   1'b0, 32'h0,    32'h0,         1'b0, 32'hA000_0108, 1'b1, 32'hA000_0100, 32'h55};
    vt[16] = '{1'b0, 32'h0,       1'b1, 1'b1, 16'h0001, 1'b0, 26'h0,   1'b0, 32'h0,    32'h40,        1'b1, 32'h44,        1'b0, 32'h0,         32'h0};
    vt[17] = '{1'b1, 32'h77,      1'b0, 1'b0, 16'h0,    1'b0, 26'h0,   1'b0, 32'h0,    32'h0,         1'b1, 32'h48,        1'b1, 32'h44,        32'h77};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   imem_req,  32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", if_valid,  32'h0);
    chk("rst_instr", if_instr,  32'h0);
    chk("rst_pc",    if_pc,     32'h0);
    chk("rst_pc4",   if_pc4,    32'h0);

    // Wrapping PC from a top-of-memory reset vector.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("w_first_req",  w_imem_req,  32'h1);
    chk("w_first_addr", w_imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    imem_ready = 1'b1;
    imem_rdata = 32'h1234;
    @(posedge clk);
    #1;
    chk("w_valid", w_if_valid,  32'h1);
    chk("w_pc",    w_if_pc,     32'hFFFF_FFFC);
    chk("w_pc4",   w_if_pc4,    32'h0);
    chk("w_instr", w_if_instr,  32'h1234);
    chk("w_addr",  w_imem_addr, 32'h0);

    // Directed vector table from a fresh reset.
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("first_req",  imem_req,  32'h1);
    chk("first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      imem_ready    = vt[i].rdy;
      imem_rdata    = vt[i].rdata;
      stall         = vt[i].stl;
      branch_taken  = vt[i].br;
      branch_offset = vt[i].off;
      jump          = vt[i].jmp;
      jump_index    = vt[i].idx;
      jr            = vt[i].jrr;
      jr_target     = vt[i].jrt;
      redirect_base = vt[i].base;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_req", i),   imem_req,  vt[i].e_req);
      chk($sformatf("v%0d_addr", i),  imem_addr, vt[i].e_addr);
      chk($sformatf("v%0d_valid", i), if_valid,  vt[i].e_valid);
      if (vt[i].e_valid) begin
        chk($sformatf("v%0d_pc", i),    if_pc,    vt[i].e_pc);
        chk($sformatf("v%0d_pc4", i),   if_pc4,   vt[i].e_pc + 32'd4);
        chk($sformatf("v%0d_instr", i), if_instr, vt[i].e_instr);
      end
    end

    // Reset asserted between edges while in HOLD clears outputs at once.
    @(negedge clk);
    idle_inputs();
    imem_ready = 1'b1;
    imem_rdata = 32'h88;
    stall      = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_req", imem_req, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", if_valid,  32'h0);
    chk("async_instr", if_instr,  32'h0);
    chk("async_pc",    if_pc,     32'h0);
    chk("async_pc4",   if_pc4,    32'h0);
    chk("async_req",   imem_req,  32'h0);
    chk("async_addr",  imem_addr, 32'h0);
    @(negedge clk);
    reset      = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h99;
    stall      = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_valid", if_valid,  32'h1);
    chk("restart_pc",    if_pc,     32'h0);
    chk("restart_instr", if_instr,  32'h99);
    chk("restart_addr",  imem_addr, 32'h4);

    // Randomized run against the reference model.
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    model_reset(32'h0);
    for (int n = 0; n < 3000; n++) begin
      int r;
      @(negedge clk);
      reset         = ($urandom_range(0, 299) == 0);
      imem_ready    = ($urandom_range(0, 3) != 0);
      imem_rdata    = $urandom;
      stall         = ($urandom_range(0, 2) == 0);
      r             = $urandom_range(0, 15);
      branch_taken  = (r == 0) || (r == 3) || (r == 4);
      jump          = (r == 1) || (r == 3) || (r == 4);
      jr            = (r == 2) || (r == 4);
      redirect_base = $urandom;
      branch_offset = 16'($urandom);
      jump_index    = 26'($urandom);
      jr_target     = $urandom;
      @(posedge clk);
      model_edge();
      #1;
      chk("rnd_req",   imem_req,  {31'h0, !reset && (m_wait.size() == 0)});
      chk("rnd_addr",  imem_addr, m_pc);
      chk("rnd_valid", if_valid,  {31'h0, m_valid});
      if (m_valid) begin
        chk("rnd_pc",    if_pc,    m_out.pc);
        chk("rnd_pc4",   if_pc4,   m_out.pc + 32'd4);
        chk("rnd_instr", if_instr, m_out.instr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 imem_req  out  1  fetch request to instruction memory.
REQ-005 imem_addr  out  32  fetch address; equals the PC register.
REQ-006 imem_ready  in  1  memory returns imem_rdata this cycle; meaningful only while imem_req=1.
REQ-007 imem_rdata  in  32  fetched instruction word.
REQ-008 stall  in  1  decode stage cannot accept a new instruction.
REQ-009 redirect_base  in  32  PC+4 of the redirecting instruction.
REQ-010 branch_taken  in  1  redirect to the branch target.
REQ-011 branch_offset  in  16  signed word offset.
REQ-012 jump  in  1  redirect to the jump target.
REQ-013 jump_index  in  26  jump word index.
REQ-014 jr  in  1  redirect to the register target.
REQ-015 jr_target  in  32  register jump address.
REQ-016 if_valid, if_instr(32), if_pc(32), if_pc4(32)  out  registered IF/ID outputs.

Function
REQ-017 States FETCH and HOLD; imem_req=1 in FETCH, 0 in HOLD.
REQ-018 Output register can load when if_valid=0 or stall=0 ("open").
REQ-019 FETCH, imem_ready=1, open: load if_instr=imem_rdata, if_pc=pc, if_pc4=pc+4, if_valid=1; pc<=pc+4; stay FETCH.
REQ-020 FETCH, imem_ready=1, not open: capture word, pc and pc+4 in a one-entry hold buffer; pc<=pc+4; go HOLD.
REQ-021 FETCH, imem_ready=0: if open, if_valid<=0; pc unchanged.
REQ-022 HOLD, stall=0: move the hold buffer to the outputs with if_valid=1; go FETCH; no memory request this cycle.
REQ-023 HOLD, stall=1: all outputs and pc hold.
REQ-024 Redirect = jr|jump|branch_taken; priority jr > jump > branch_taken.
REQ-025 Branch target = redirect_base + (sign-extended branch_offset << 2), modulo 2^32.
REQ-026 Jump target = {redirect_base[31:28], jump_index, 2'b00}.
REQ-027 JR target = {jr_target[31:2], 2'b00}.
REQ-028 Any redirect, in either state: pc<=target, if_valid<=0, hold buffer discarded, state<=FETCH.
REQ-029 Redirect overrides stall and any same-cycle imem_ready; the returned word is discarded.
REQ-030 imem_addr changes immediately after a redirect; an abandoned request is never retried.
REQ-031 PC increment wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no error flag.
REQ-032 Fetch throughput is one instruction per cycle with imem_ready=1 and stall=0; latency is 1 cycle from imem_ready to if_valid.
REQ-033 An instruction is presented exactly once; none is lost or duplicated across stall or HOLD.

Reset
REQ-034 While reset=1: pc=RESET_PC, state=FETCH, imem_req=0, if_valid=0, if_instr=if_pc=if_pc4=0, hold buffer empty.
REQ-035 First rising edge after reset release: imem_req=1, imem_addr=RESET_PC.
REQ-036 Reset mid-fetch or in HOLD abandons all state with no output glitch beyond REQ-034.

Verification
REQ-037 Reset release, imem_ready=1 every cycle, stall=0, rdata=addr -> if_pc sequence 0,4,8,12 with if_instr equal to if_pc, one per cycle.
REQ-038 Stall asserted while if_valid=1 and imem_ready=1 -> HOLD, imem_req=0; stall released -> buffered instruction presented once, then fetch resumes at the next PC.
REQ-039 branch_taken=1, redirect_base=0x100, offset=16'hFFFE -> next imem_addr=0xF8, if_valid=0 that cycle, returned word dropped.
REQ-040 jr=1 and jump=1 together, jr_target=0x2003 -> imem_addr=0x2000; jump ignored.
REQ-041 RESET_PC=32'hFFFF_FFFC, one fetch -> if_pc=FFFF_FFFC, if_pc4=0, next imem_addr=0.
REQ-042 Assert reset while in HOLD -> outputs clear immediately, not on the clock edge; fetch restarts at RESET_PC.
